planificador_sensores: RTL and testbench

Round-robin scan scheduler that shares one temperature-classification and persistence datapath among `NUM_CH` sensor channels. It requests one sample per channel through a req/valid handshake, applies a per-channel timeout, and classifies each sample as frío, normal or calor. It keeps a per-channel persistence counter and drives the shared actuators (`calefactor`, `ventilador`) and the global `alerta`. It sits between the sensor front-ends and the actuator drivers, and replaces per-sensor monitor instances.

---
 rtl/planificador_sensores.sv | 171 +++++++++++++++++
 tb/tb_planificador_sensores.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/planificador_sensores.sv
// Round-robin scan scheduler: polls NUM_CH sensors through one shared classification
// and persistence datapath and drives the shared heater/fan/alert outputs.
module planificador_sensores #(
   parameter int NUM_CH      = 4,
   parameter int TEMP_W      = 9,
   parameter int UMBRAL_BAJO = 180,
   parameter int UMBRAL_ALTO = 260,
   parameter int PERSIST     = 6,
   parameter int TIMEOUT     = 15
) (
   input  logic                       clk,
   input  logic                       arst_n,
   output logic [NUM_CH-1:0]          sensor_req,
   input  logic [NUM_CH-1:0]          sensor_valid,
   input  logic [NUM_CH*TEMP_W-1:0]   sensor_dato,
   output logic [$clog2(NUM_CH)-1:0]  canal_activo,
   output logic [NUM_CH-1:0]          ch_alerta,
   output logic [NUM_CH-1:0]          ch_falla,
   output logic                       alerta,
   output logic                       calefactor,
   output logic                       ventilador,
   output logic [1:0]                 estado_fsm
);

   localparam int PTR_W = $clog2(NUM_CH);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int CNT_W = $clog2(PERSIST + 1);

   localparam logic [TEMP_W-1:0] BAJO_T    = TEMP_W'(UMBRAL_BAJO);
   localparam logic [TEMP_W-1:0] ALTO_T    = TEMP_W'(UMBRAL_ALTO);
   localparam logic [TMO_W-1:0]  TMO_LIM   = TMO_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  PERSIST_C = CNT_W'(PERSIST);
   localparam logic [PTR_W-1:0]  PTR_ULT   = PTR_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      EVAL = 2'b10,
      NEXT = 2'b11
   } estado_t;

   typedef enum logic [1:0] {
      CAT_NORMAL = 2'b00,
      CAT_FRIO   = 2'b01,
      CAT_CALOR  = 2'b10
   } cat_t;

   estado_t            estado, estado_sig;
   logic [PTR_W-1:0]   ptr;
   logic [TMO_W-1:0]   tmo_cnt;
   logic [TEMP_W-1:0]  muestra;
   logic [CNT_W-1:0]   cnt_ch [NUM_CH];
   cat_t               cat_ch [NUM_CH];

   logic               valid_sel;
   logic               tmo_fin;
   logic [TEMP_W-1:0]  dato_sel;
   cat_t               cat_nueva, cat_act, cat_sig;
   logic [CNT_W-1:0]   cnt_act, cnt_sig;
   logic               alerta_sig;
   logic               hay_frio, hay_calor;

   assign valid_sel    = sensor_valid[ptr];
   assign dato_sel     = sensor_dato[int'(ptr)*TEMP_W +: TEMP_W];
   assign tmo_fin      = (tmo_cnt == TMO_LIM);
   assign canal_activo = ptr;
   assign estado_fsm   = estado;

   always_ff @(posedge clk) begin
      if (!arst_n) estado <= IDLE;
      else         estado <= estado_sig;
   end

   // A valid sample takes priority over a timeout landing on the same edge.
   always_comb begin
      estado_sig = estado;
      sensor_req = '0;
      case (estado)
         IDLE: estado_sig = REQ;
         REQ: begin
            sensor_req[ptr] = 1'b1;
            if (valid_sel)    estado_sig = EVAL;
            else if (tmo_fin) estado_sig = NEXT;
         end
         EVAL:    estado_sig = NEXT;
         NEXT:    estado_sig = REQ;
         default: estado_sig = IDLE;
      endcase
   end

   // Classification of the captured sample and the resulting persistence update.
   always_comb begin
      cat_nueva = CAT_NORMAL;
      if (muestra < BAJO_T)       cat_nueva = CAT_FRIO;
      else if (muestra >= ALTO_T) cat_nueva = CAT_CALOR;

      cnt_act = cnt_ch[ptr];
      cat_act = cat_ch[ptr];
      cnt_sig = '0;
      cat_sig = CAT_NORMAL;
      if (cat_nueva == CAT_NORMAL) begin
         cnt_sig = '0;
         cat_sig = CAT_NORMAL;
      end else if (cat_nueva == cat_act) begin
         cnt_sig = (cnt_act >= PERSIST_C) ? PERSIST_C : cnt_act + CNT_W'(1);
         cat_sig = cat_act;
      end else begin
         cnt_sig = CNT_W'(1);
         cat_sig = cat_nueva;
      end
      alerta_sig = (cnt_sig == PERSIST_C);
   end

   always_comb begin
      hay_frio  = 1'b0;
      hay_calor = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_alerta[i] && cat_ch[i] == CAT_FRIO)  hay_frio  = 1'b1;
         if (ch_alerta[i] && cat_ch[i] == CAT_CALOR) hay_calor = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         ptr        <= '0;
         tmo_cnt    <= '0;
         muestra    <= '0;
         ch_alerta  <= '0;
         ch_falla   <= '0;
         alerta     <= 1'b0;
         calefactor <= 1'b0;
         ventilador <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_ch[i] <= '0;
            cat_ch[i] <= CAT_NORMAL;
         end
      end else begin
         case (estado)
            IDLE: begin
               ptr     <= '0;
               tmo_cnt <= '0;
            end
            REQ: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               if (valid_sel) begin
                  muestra       <= dato_sel;
                  ch_falla[ptr] <= 1'b0;
               end else if (tmo_fin) begin
                  ch_falla[ptr] <= 1'b1;
               end
            end
            EVAL: begin
               cnt_ch[ptr]    <= cnt_sig;
               cat_ch[ptr]    <= cat_sig;
               ch_alerta[ptr] <= alerta_sig;
            end
            NEXT: begin
               ptr     <= (ptr == PTR_ULT) ? '0 : ptr + PTR_W'(1);
               tmo_cnt <= '0;
            end
            default: ;
         endcase

         // Opposing alerts cancel both actuators but keep the global alert.
         alerta     <= |ch_alerta;
         calefactor <= hay_frio & ~hay_calor;
         ventilador <= hay_calor & ~hay_frio;
      end
   end

endmodule

// File: tb/tb_planificador_sensores.sv
// Self-checking bench for planificador_sensores: a transaction-level model predicts each
// channel slot and a scoreboard queue holds the expectations until the DUT finishes the slot.
module tb_planificador_sensores;

   localparam int NUM_CH  = 4;
   localparam int TEMP_W  = 9;
   localparam int BAJO    = 180;
   localparam int ALTO    = 260;
   localparam int PERSIST = 6;
   localparam int TIMEOUT = 15;

   logic                      clk;
   logic                      arst_n;
   logic [NUM_CH-1:0]         sensor_req;
   logic [NUM_CH-1:0]         sensor_valid;
   logic [NUM_CH*TEMP_W-1:0]  sensor_dato;
   logic [1:0]                canal_activo;
   logic [NUM_CH-1:0]         ch_alerta;
   logic [NUM_CH-1:0]         ch_falla;
   logic                      alerta;
   logic                      calefactor;
   logic                      ventilador;
   logic [1:0]                estado_fsm;

   planificador_sensores #(
      .NUM_CH(NUM_CH), .TEMP_W(TEMP_W), .UMBRAL_BAJO(BAJO),
      .UMBRAL_ALTO(ALTO), .PERSIST(PERSIST), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .arst_n(arst_n), .sensor_req(sensor_req), .sensor_valid(sensor_valid),
      .sensor_dato(sensor_dato), .canal_activo(canal_activo), .ch_alerta(ch_alerta),
      .ch_falla(ch_falla), .alerta(alerta), .calefactor(calefactor),
      .ventilador(ventilador), .estado_fsm(estado_fsm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int                ch;
      int                req_cycles;
      logic              accepted;
      logic [NUM_CH-1:0] exp_alerta;
      logic [NUM_CH-1:0] exp_falla;
      logic              exp_glob;
      logic              exp_cal;
      logic              exp_ven;
   } sb_t;

   sb_t sb[$];

   int   checks = 0;
   int   errors = 0;
   int   m_cnt [NUM_CH];
   int   m_cat [NUM_CH];
   logic m_al  [NUM_CH];
   logic m_fa  [NUM_CH];

   task automatic model_clear();
      for (int i = 0; i < NUM_CH; i++) begin
         m_cnt[i] = 0; m_cat[i] = 0; m_al[i] = 1'b0; m_fa[i] = 1'b0;
      end
      sb.delete();
   endtask

   // Category codes: 0 normal, 1 cold, 2 hot.
   task automatic model_slot(input int ch, input logic v, input int d, input int rc, output sb_t e);
      int c;
      logic af, ac, any;
      if (v) begin
         c = (d < BAJO) ? 1 : ((d >= ALTO) ? 2 : 0);
         if (c == 0) begin
            m_cnt[ch] = 0; m_cat[ch] = 0;
         end else if (c == m_cat[ch]) begin
            if (m_cnt[ch] < PERSIST) m_cnt[ch] = m_cnt[ch] + 1;
         end else begin
            m_cnt[ch] = 1; m_cat[ch] = c;
         end
         m_al[ch] = (m_cnt[ch] == PERSIST);
         m_fa[ch] = 1'b0;
      end else begin
         m_fa[ch] = 1'b1;
      end
      af = 1'b0; ac = 1'b0; any = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         e.exp_alerta[i] = m_al[i];
         e.exp_falla[i]  = m_fa[i];
         if (m_al[i]) any = 1'b1;
         if (m_al[i] && m_cat[i] == 1) af = 1'b1;
         if (m_al[i] && m_cat[i] == 2) ac = 1'b1;
      end
      e.ch = ch; e.req_cycles = rc; e.accepted = v;
      e.exp_glob = any; e.exp_cal = af & ~ac; e.exp_ven = ac & ~af;
   endtask

   // Follows one channel slot from REQ to the cycle after NEXT and compares against the queue.
   task automatic do_slot(input int ch, input int late);
      sb_t e;
      int waited = 0;
      int nreq = 0;
      logic [NUM_CH-1:0] exp_req;
      if (sb.size() == 0) begin
         errors++; checks++;
         $display("[TB] FAIL scoreboard_empty ch%0d: got 0 entries, required 1", ch);
         return;
      end
      e = sb.pop_front();
      while (!(estado_fsm == 2'b01 && canal_activo == 2'(ch))) begin
         @(negedge clk);
         waited++;
         if (waited > 100) begin
            errors++; checks++;
            $display("[TB] FAIL req_wait ch%0d: REQ never reached, state %b ptr %0d", ch, estado_fsm, canal_activo);
            return;
         end
      end
      exp_req = 4'b0001 << ch;
      checks++;
      if (sensor_req !== exp_req) begin
         errors++;
         $display("[TB] FAIL sensor_req ch%0d: got %b required %b", ch, sensor_req, exp_req);
      end
      while (estado_fsm == 2'b01 && nreq < 40) begin
         nreq++;
         if (nreq == late) sensor_valid[ch] = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (nreq != e.req_cycles) begin
         errors++;
         $display("[TB] FAIL req_cycles ch%0d: got %0d required %0d", ch, nreq, e.req_cycles);
      end
      if (e.accepted) begin
         checks++;
         if (estado_fsm !== 2'b10) begin
            errors++;
            $display("[TB] FAIL state_eval ch%0d: got %b required 10", ch, estado_fsm);
         end
         @(negedge clk);
      end
      checks++;
      if (estado_fsm !== 2'b11 || ch_alerta !== e.exp_alerta || ch_falla !== e.exp_falla) begin
         errors++;
         $display("[TB] FAIL slot_flags ch%0d: got state %b alerta %b falla %b required 11 %b %b",
                  ch, estado_fsm, ch_alerta, ch_falla, e.exp_alerta, e.exp_falla);
      end
      @(negedge clk);
      checks++;
      if ({alerta, calefactor, ventilador} !== {e.exp_glob, e.exp_cal, e.exp_ven}) begin
         errors++;
         $display("[TB] FAIL actuators ch%0d: got %b required %b", ch,
                  {alerta, calefactor, ventilador}, {e.exp_glob, e.exp_cal, e.exp_ven});
      end
   endtask

   // One full scan; late_ch (or -1) gets its valid only on the last allowed REQ cycle.
   task automatic scan(input int v0, input int v1, input int v2, input int v3,
                       input logic [NUM_CH-1:0] valid, input int late_ch);
      int vals [NUM_CH];
      sb_t e;
      vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
      for (int i = 0; i < NUM_CH; i++) sensor_dato[i*TEMP_W +: TEMP_W] = 9'(vals[i]);
      sensor_valid = valid;
      for (int i = 0; i < NUM_CH; i++) begin
         if (i == late_ch)     model_slot(i, 1'b1, vals[i], TIMEOUT, e);
         else if (valid[i])    model_slot(i, 1'b1, vals[i], 1, e);
         else                  model_slot(i, 1'b0, vals[i], TIMEOUT, e);
         sb.push_back(e);
      end
      for (int i = 0; i < NUM_CH; i++) do_slot(i, (i == late_ch) ? TIMEOUT : 0);
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_clear();
      arst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_vec(input string name, input logic [3:0] got, input logic [3:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %b required %b", name, got, req);
      end
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      sensor_valid = '0;
      sensor_dato = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({sensor_req, canal_activo, ch_alerta, ch_falla, alerta, calefactor, ventilador, estado_fsm} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got req %b ptr %0d al %b fa %b g%b c%b v%b st %b required all 0",
                  sensor_req, canal_activo, ch_alerta, ch_falla, alerta, calefactor, ventilador, estado_fsm);
      end
      model_clear();
      arst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (estado_fsm !== 2'b01 || sensor_req !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL reset_release: got state %b req %b required 01 0001", estado_fsm, sensor_req);
      end
   endtask

   task automatic test_normal_scan();
      scan(220, 220, 220, 220, 4'b1111, -1);
      scan(220, 220, 220, 220, 4'b1111, -1);
   endtask

   task automatic test_persist();
      do_reset();
      for (int n = 0; n < 6; n++) scan(220, 220, 170, 220, 4'b1111, -1);
      check_vec("persist_alerta", ch_alerta, 4'b0100);
      check_vec("persist_outputs", {1'b0, alerta, calefactor, ventilador}, 4'b0110);
      scan(220, 220, 200, 220, 4'b1111, -1);
      check_vec("persist_clear", {1'b0, alerta, calefactor, ventilador}, 4'b0000);
   endtask

   task automatic test_boundary();
      do_reset();
      for (int n = 0; n < 6; n++) scan(179, 220, 220, 220, 4'b1111, -1);
      check_vec("bound_179", ch_alerta, 4'b0001);
      scan(180, 220, 220, 220, 4'b1111, -1);
      check_vec("bound_180", ch_alerta, 4'b0000);
      for (int n = 0; n < 6; n++) scan(259, 220, 220, 220, 4'b1111, -1);
      check_vec("bound_259", ch_alerta, 4'b0000);
      for (int n = 0; n < 6; n++) scan(260, 220, 220, 220, 4'b1111, -1);
      check_vec("bound_260", {1'b0, alerta, calefactor, ventilador}, 4'b0101);
   endtask

   task automatic test_category_change();
      do_reset();
      for (int n = 0; n < 5; n++) scan(220, 300, 220, 220, 4'b1111, -1);
      scan(220, 150, 220, 220, 4'b1111, -1);
      for (int n = 0; n < 5; n++) scan(220, 300, 220, 220, 4'b1111, -1);
      check_vec("cat_change", ch_alerta, 4'b0000);
   endtask

   task automatic test_timeout();
      do_reset();
      scan(220, 220, 220, 220, 4'b0111, -1);
      check_vec("timeout_falla", ch_falla, 4'b1000);
      scan(220, 220, 220, 220, 4'b1111, -1);
      check_vec("timeout_clear", ch_falla, 4'b0000);
      scan(220, 220, 220, 170, 4'b0111, 3);
      check_vec("timeout_late_valid", ch_falla, 4'b0000);
   endtask

   task automatic test_conflict_and_reset();
      do_reset();
      for (int n = 0; n < 6; n++) scan(170, 300, 220, 220, 4'b1111, -1);
      check_vec("conflict", {1'b0, alerta, calefactor, ventilador}, 4'b0100);
      sensor_valid = '0;
      @(negedge clk);
      check_vec("mid_req_state", {2'b00, estado_fsm}, 4'b0001);
      arst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({sensor_req, canal_activo, ch_alerta, ch_falla, alerta, calefactor, ventilador, estado_fsm} !== '0) begin
         errors++;
         $display("[TB] FAIL mid_req_reset: got req %b al %b fa %b g%b c%b v%b st %b required all 0",
                  sensor_req, ch_alerta, ch_falla, alerta, calefactor, ventilador, estado_fsm);
      end
      model_clear();
      arst_n = 1'b1;
      @(negedge clk);
      scan(220, 220, 220, 220, 4'b1111, -1);
   endtask

   initial begin
      test_reset();
      test_normal_scan();
      test_persist();
      test_boundary();
      test_category_change();
      test_timeout();
      test_conflict_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
